filter_ctrl: RTL

Sequencer and arbiter placed in front of the 7-tap FIR filter's configuration and sample ports. It forwards single-byte CPU coefficient writes and performs atomic bulk reloads of all 8 parameter bytes (7 taps plus input mask). During a reload it stalls the sample stream, buffering samples in a small FIFO so none are lost. Every output to the filter is registered.

---
 rtl/filter_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/filter_ctrl.sv
// Sequencer/arbiter in front of the 7-tap FIR: CPU byte writes, atomic 8-byte reloads, sample FIFO.
// Optional FILTER_CTRL_FLUSH_EN: clears the filter delay line with 7 zero samples after a reload.
module filter_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cpu_w_en_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_p,
  output logic        cpu_rej,
  input  logic        ld_req,
  input  logic [63:0] ld_coef,
  output logic        ld_busy,
  output logic        ld_ack,
  input  logic        s_valid_n,
  input  logic [7:0]  s_x,
  output logic        s_ready,
  output logic        f_w_en_n,
  output logic [7:0]  f_p,
  output logic [15:0] f_addr,
  output logic        f_x_valid_n,
  output logic [7:0]  f_x
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
`ifdef FILTER_CTRL_FLUSH_EN
    StFlush = 2'd3,
`endif
    StDone  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [63:0] shadow_q, shadow_d;

  logic        f_w_en_n_d, f_x_valid_n_d, cpu_rej_d, ld_ack_d, ld_busy_d, s_ready_d;
  logic [7:0]  f_p_d, f_x_d;
  logic [15:0] f_addr_d;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            accept, push, pop;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    shadow_d      = shadow_q;
    f_w_en_n_d    = 1'b1;
    f_addr_d      = f_addr;
    f_p_d         = f_p;
    f_x_valid_n_d = 1'b1;
    f_x_d         = f_x;
    cpu_rej_d     = 1'b0;
    ld_ack_d      = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    accept        = ~s_valid_n & s_ready;

    unique case (state_q)
      StIdle: begin
        // A CPU write in the same cycle wins; the reload request stays pending.
        if (!cpu_w_en_n) begin
          f_w_en_n_d = 1'b0;
          f_addr_d   = cpu_addr;
          f_p_d      = cpu_p;
        end else if (ld_req) begin
          shadow_d = ld_coef;
          k_d      = 3'd0;
          state_d  = StLoad;
        end
        if (count_q != '0) begin
          pop           = 1'b1;
          push          = accept;
          f_x_valid_n_d = 1'b0;
          f_x_d         = mem_q[rd_ptr_q];
        end else if (accept) begin
          f_x_valid_n_d = 1'b0;
          f_x_d         = s_x;
        end
      end
      StLoad: begin
        f_w_en_n_d = 1'b0;
        f_addr_d   = {13'd0, k_q};
        f_p_d      = shadow_q[8*k_q +: 8];
        k_d        = k_q + 3'd1;
        if (k_q == 3'd7) begin
          k_d = 3'd0;
`ifdef FILTER_CTRL_FLUSH_EN
          state_d = StFlush;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef FILTER_CTRL_FLUSH_EN
      StFlush: begin
        f_x_valid_n_d = 1'b0;
        f_x_d         = 8'h00;
        k_d           = k_q + 3'd1;
        if (k_q == 3'd6) begin
          k_d     = 3'd0;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        ld_ack_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      cpu_rej_d = ~cpu_w_en_n;
      push      = accept;
    end
    ld_busy_d = (state_d != StIdle) || (state_q != StIdle);

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    // Registered ready tracks the registered count, so a full FIFO never sees a push.
    s_ready_d = (count_d < CntW'(DEPTH));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= 3'd0;
      shadow_q    <= 64'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      f_w_en_n    <= 1'b1;
      f_addr      <= 16'd0;
      f_p         <= 8'd0;
      f_x_valid_n <= 1'b1;
      f_x         <= 8'd0;
      cpu_rej     <= 1'b0;
      ld_ack      <= 1'b0;
      ld_busy     <= 1'b0;
      s_ready     <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      f_w_en_n    <= f_w_en_n_d;
      f_addr      <= f_addr_d;
      f_p         <= f_p_d;
      f_x_valid_n <= f_x_valid_n_d;
      f_x         <= f_x_d;
      cpu_rej     <= cpu_rej_d;
      ld_ack      <= ld_ack_d;
      ld_busy     <= ld_busy_d;
      s_ready     <= s_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_x;
    end
  end

endmodule
